// File: rtl/parking_lot_counter_if.sv
// Sensor inputs and per-gate event / occupancy outputs of the parking lot counter.
// master drives the photo-sensors; slave is the counter itself.
interface parking_lot_counter_if #(
  parameter int N_GATES = 2,
  parameter int CNT_W   = 5
);
  logic [N_GATES-1:0] a;
  logic [N_GATES-1:0] b;
  logic [N_GATES-1:0] enter;
  logic [N_GATES-1:0] exit;
  logic [N_GATES-1:0] err;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               ovf;

  modport master (
    output a, b,
    input  enter, exit, err, occupancy, full, empty, ovf
  );

  modport slave (
    input  a, b,
    output enter, exit, err, occupancy, full, empty, ovf
  );
endinterface

// File: rtl/parking_lot_counter.sv
// Multi-gate parking lot counter: one Moore FSM per a/b sensor pair decodes
// entries/exits; a clamped occupancy register nets all gates each cycle.
module parking_lot_counter #(
  parameter int N_GATES  = 2,
  parameter int CAPACITY = 25,
  parameter int CNT_W    = 5
) (
  input logic                clk,
  input logic                reset,
  parking_lot_counter_if.slave bus
);

  localparam int DW = $clog2(N_GATES + 1) + 1;
  localparam int SW = CNT_W + DW + 1;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  typedef enum logic [3:0] {
    IDLE, EN1, EN2, EN3, EN_DONE, EX1, EX2, EX3, EX_DONE, ERR
  } state_t;

  state_t state     [N_GATES];
  state_t state_nxt [N_GATES];

  logic [CNT_W-1:0]      occ;
  logic                  ovf_q;
  logic [N_GATES-1:0]    enter_v, exit_v, err_v;
  logic [DW-1:0]         n_in, n_out;
  logic signed [DW-1:0]  delta;
  logic signed [SW-1:0]  sum;

  function automatic state_t next_state(input state_t s, input logic [1:0] ab);
    next_state = s;
    unique case (s)
      EN1: unique case (ab)
             2'b10: next_state = EN1;
             2'b11: next_state = EN2;
             2'b00: next_state = IDLE;
             default: next_state = ERR;
           endcase
      EN2: unique case (ab)
             2'b11: next_state = EN2;
             2'b10: next_state = EN1;
             2'b01: next_state = EN3;
             default: next_state = ERR;
           endcase
      EN3: unique case (ab)
             2'b01: next_state = EN3;
             2'b11: next_state = EN2;
             2'b00: next_state = EN_DONE;
             default: next_state = ERR;
           endcase
      EX1: unique case (ab)
             2'b01: next_state = EX1;
             2'b11: next_state = EX2;
             2'b00: next_state = IDLE;
             default: next_state = ERR;
           endcase
      EX2: unique case (ab)
             2'b11: next_state = EX2;
             2'b01: next_state = EX1;
             2'b10: next_state = EX3;
             default: next_state = ERR;
           endcase
      EX3: unique case (ab)
             2'b10: next_state = EX3;
             2'b11: next_state = EX2;
             2'b00: next_state = EX_DONE;
             default: next_state = ERR;
           endcase
      // IDLE and the terminal states all behave as a resting gate
      default: unique case (ab)
             2'b10: next_state = EN1;
             2'b01: next_state = EX1;
             2'b00: next_state = IDLE;
             default: next_state = ERR;
           endcase
    endcase
  endfunction

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_GATES; i++) begin
      if (reset) state[i] <= IDLE;
      else       state[i] <= state_nxt[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_GATES; i++) begin
      state_nxt[i] = next_state(state[i], {bus.a[i], bus.b[i]});
    end
  end

  always_comb begin
    enter_v = '0;
    exit_v  = '0;
    err_v   = '0;
    n_in    = '0;
    n_out   = '0;
    for (int unsigned i = 0; i < N_GATES; i++) begin
      enter_v[i] = (state[i] == EN_DONE);
      exit_v[i]  = (state[i] == EX_DONE);
      err_v[i]   = (state[i] == ERR);
      n_in       = n_in  + DW'(enter_v[i]);
      n_out      = n_out + DW'(exit_v[i]);
    end
  end

  // Sum is widened so both overflow past CAPACITY and underflow below 0 stay visible
  assign delta = $signed(n_in - n_out);
  assign sum   = $signed({{(SW-CNT_W){1'b0}}, occ}) + $signed({{(SW-DW){delta[DW-1]}}, delta});

  always_ff @(posedge clk) begin
    if (reset) begin
      occ   <= '0;
      ovf_q <= 1'b0;
    end else if (sum > CAP_S) begin
      occ   <= CNT_W'(CAPACITY);
      ovf_q <= 1'b1;
    end else if (sum < 0) begin
      occ   <= '0;
      ovf_q <= 1'b1;
    end else begin
      occ   <= sum[CNT_W-1:0];
      ovf_q <= 1'b0;
    end
  end

  assign bus.enter     = enter_v;
  assign bus.exit      = exit_v;
  assign bus.err       = err_v;
  assign bus.occupancy = occ;
  assign bus.ovf       = ovf_q;
  assign bus.full      = (occ == CNT_W'(CAPACITY));
  assign bus.empty     = (occ == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Randomized and directed bench for parking_lot_counter, checked against a
// position-along-the-gate reference model kept in the bench.
module tb_parking_lot_counter;
  localparam int N   = 2;
  localparam int CAP = 25;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  parking_lot_counter_if #(.N_GATES(N), .CNT_W(CW)) bus ();

  parking_lot_counter #(.N_GATES(N), .CAPACITY(CAP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: per gate, the car's position (0 = none) along its direction of travel
  int mp [N];
  int md [N];
  logic [N-1:0] m_en, m_ex, m_er;
  int   m_occ;
  logic m_ovf;
  int   ovf_seen;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos(input int dir, input logic [1:0] ab);
    if (ab == 2'b00) return 0;
    if (ab == 2'b11) return 2;
    if (dir > 0) return (ab == 2'b10) ? 1 : 3;
    return (ab == 2'b01) ? 1 : 3;
  endfunction

  task automatic model_step(input logic rst, input logic [N-1:0] av, input logic [N-1:0] bv);
    int s, q;
    logic [1:0] ab;
    if (rst) begin
      for (int g = 0; g < N; g++) begin mp[g] = 0; md[g] = 0; end
      m_en = '0; m_ex = '0; m_er = '0; m_occ = 0; m_ovf = 1'b0;
      return;
    end
    s = m_occ + $countones(m_en) - $countones(m_ex);
    m_ovf = (s > CAP) || (s < 0);
    m_occ = (s > CAP) ? CAP : (s < 0) ? 0 : s;
    m_en = '0; m_ex = '0; m_er = '0;
    for (int g = 0; g < N; g++) begin
      ab = {av[g], bv[g]};
      if (mp[g] == 0) begin
        if (ab == 2'b10)      begin md[g] = 1;  mp[g] = 1; end
        else if (ab == 2'b01) begin md[g] = -1; mp[g] = 1; end
        else if (ab == 2'b11) m_er[g] = 1'b1;
      end else begin
        q = pos(md[g], ab);
        if (q == mp[g]) begin
        end else if (mp[g] == 3 && q == 0) begin
          if (md[g] > 0) m_en[g] = 1'b1; else m_ex[g] = 1'b1;
          mp[g] = 0;
        end else if (q - mp[g] == 1 || mp[g] - q == 1) begin
          mp[g] = q;
        end else begin
          m_er[g] = 1'b1;
          mp[g] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    reset = rst;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    model_step(rst, av, bv);
    #1;
    check("enter", bus.enter, m_en);
    check("exit", bus.exit, m_ex);
    check("err", bus.err, m_er);
    check("occupancy", bus.occupancy, m_occ);
    check("full", bus.full, (m_occ == CAP));
    check("empty", bus.empty, (m_occ == 0));
    check("ovf", bus.ovf, m_ovf);
    if (bus.ovf === 1'b1) ovf_seen++;
  endtask

  task automatic push(input int g, input logic [1:0] ab);
    logic [N-1:0] av, bv;
    av = '0; bv = '0;
    av[g] = ab[1];
    bv[g] = ab[0];
    cyc(1'b0, av, bv);
  endtask

  task automatic car_in(input int g);
    push(g, 2'b10); push(g, 2'b11); push(g, 2'b01); push(g, 2'b00);
  endtask

  task automatic car_out(input int g);
    push(g, 2'b01); push(g, 2'b11); push(g, 2'b10); push(g, 2'b00);
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    cyc(1'b1, '0, '0);
    cyc(1'b1, '0, '0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_empty", bus.empty, 1);

    // single entry then exit on the other gate
    car_in(0);
    check("entry_pulse", bus.enter, 2'b01);
    push(0, 2'b00);
    check("entry_occ", bus.occupancy, 1);
    check("entry_empty", bus.empty, 0);
    car_out(1);
    check("exit_pulse", bus.exit, 2'b10);
    push(1, 2'b00);
    check("exit_occ", bus.occupancy, 0);

    // reversal still counts once; backing out counts nothing
    ovf_seen = 0;
    push(0, 2'b10); push(0, 2'b11); push(0, 2'b10); push(0, 2'b11);
    push(0, 2'b01); push(0, 2'b00); push(0, 2'b00); push(0, 2'b00);
    check("reversal_occ", bus.occupancy, 1);
    push(0, 2'b10); push(0, 2'b11); push(0, 2'b10); push(0, 2'b00);
    push(0, 2'b00);
    check("backout_occ", bus.occupancy, 1);

    // reach 5, then simultaneous entry on gate 0 and exit on gate 1
    for (int k = 0; k < 4; k++) car_in(0);
    push(0, 2'b00);
    check("pre_simul_occ", bus.occupancy, 5);
    cyc(1'b0, 2'b01, 2'b10);
    cyc(1'b0, 2'b11, 2'b11);
    cyc(1'b0, 2'b10, 2'b01);
    cyc(1'b0, 2'b00, 2'b00);
    check("simul_enter", bus.enter, 2'b01);
    check("simul_exit", bus.exit, 2'b10);
    push(0, 2'b00);
    check("simul_occ", bus.occupancy, 5);

    // fill past capacity
    ovf_seen = 0;
    for (int k = 0; k < CAP - 5 + 1; k++) car_in(0);
    push(0, 2'b00); push(0, 2'b00);
    check("cap_occ", bus.occupancy, CAP);
    check("cap_full", bus.full, 1);
    check("cap_ovf_count", ovf_seen, 1);

    // drain below zero
    for (int k = 0; k < CAP; k++) car_out(1);
    push(1, 2'b00); push(1, 2'b00);
    ovf_seen = 0;
    car_out(1);
    push(1, 2'b00); push(1, 2'b00);
    check("under_occ", bus.occupancy, 0);
    check("under_ovf_count", ovf_seen, 1);

    // illegal 11 from idle, then reset in the middle of an entry
    push(0, 2'b11);
    check("err_pulse", bus.err, 2'b01);
    push(0, 2'b00);
    car_in(0);
    push(0, 2'b00);
    push(0, 2'b10); push(0, 2'b11);
    cyc(1'b1, 2'b01, 2'b01);
    check("rst_mid_occ", bus.occupancy, 0);
    push(0, 2'b01); push(0, 2'b00); push(0, 2'b00);
    check("rst_mid_enter", bus.enter, 0);

    // random sensor activity with occasional reset
    for (int k = 0; k < 1500; k++) begin
      logic [N-1:0] av, bv;
      av = N'($urandom);
      bv = N'($urandom);
      cyc(($urandom_range(0, 99) == 0), av, bv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/parking_lot_counter.md
PARKING_LOT_COUNTER -- requirements
Module: parking_lot_counter

Interface
REQ-001 Parameter N_GATES, default 2, number of independent gates, each with one a/b photo-sensor pair.
REQ-002 Parameter CAPACITY, default 25, maximum lot occupancy.
REQ-003 Parameter CNT_W, default 5, occupancy width; SHALL satisfy 2**CNT_W > CAPACITY.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 a  input  N_GATES  outer sensor per gate; 1 = beam blocked.
REQ-007 b  input  N_GATES  inner sensor per gate; 1 = beam blocked.
REQ-008 enter  output  N_GATES  one-cycle pulse per gate on each completed entry.
REQ-009 exit  output  N_GATES  one-cycle pulse per gate on each completed exit.
REQ-010 err  output  N_GATES  one-cycle pulse per gate on an illegal sensor transition.
REQ-011 occupancy  output  CNT_W  current car count, 0..CAPACITY.
REQ-012 full  output  1  high iff occupancy == CAPACITY.
REQ-013 empty  output  1  high iff occupancy == 0.
REQ-014 ovf  output  1  one-cycle pulse when the count is clamped at CAPACITY or at 0.

Function
REQ-015 Each gate SHALL run an identical Moore FSM; enter/exit/err SHALL be functions of registered state only. Below, ab = {a[i],b[i]}.
REQ-016 States: IDLE, EN1, EN2, EN3, EN_DONE, EX1, EX2, EX3, EX_DONE, ERR.
REQ-017 IDLE, EN_DONE, EX_DONE, ERR transitions: 10->EN1, 01->EX1, 00->IDLE, 11->ERR.
REQ-018 EN1: 10 stay, 11->EN2, 00->IDLE (car backed out), 01->ERR.
REQ-019 EN2: 11 stay, 10->EN1, 01->EN3, 00->ERR.
REQ-020 EN3: 01 stay, 11->EN2, 00->EN_DONE, 10->ERR.
REQ-021 EX1/EX2/EX3 SHALL mirror EN1/EN2/EN3 with a and b swapped; EX3 on 00 -> EX_DONE.
REQ-022 enter[i]=1 iff gate i is in EN_DONE; exit[i]=1 iff in EX_DONE; err[i]=1 iff in ERR; each lasts exactly one cycle unless the same terminal state is re-entered.
REQ-023 Latency: an enter/exit pulse SHALL be high in the cycle after the edge that samples ab=00 from EN3/EX3.
REQ-024 Each cycle, delta = popcount(enter) - popcount(exit), a signed value of width clog2(N_GATES+1)+1 bits; simultaneous events on different gates SHALL net in the same cycle.
REQ-025 At each edge, occupancy <= clamp(occupancy + delta, 0, CAPACITY); the updated count SHALL be visible one cycle after the pulses.
REQ-026 ovf SHALL pulse in the cycle after any edge where the unclamped sum was > CAPACITY or < 0; in that case occupancy SHALL hold the clamped bound.
REQ-027 full and empty SHALL be combinational decodes of the registered occupancy.
REQ-028 An err pulse SHALL NOT alter occupancy.

Reset
REQ-029 While reset is high at an edge, every gate FSM SHALL go to IDLE, and occupancy SHALL be 0; consequently enter, exit, err and ovf SHALL be 0, empty 1, and full 0.
REQ-030 Reset SHALL override in-progress sequences; a sequence interrupted by reset SHALL NOT produce a pulse, and the gate SHALL restart from IDLE.

Verification
REQ-031 Gate 0 ab sequence 10,11,01,00 -> enter[0] high for one cycle; next cycle occupancy=1, empty=0.
REQ-032 Gate 1 sequence 01,11,10,00 at occupancy=1 -> exit[1] pulse; occupancy=0, empty=1, ovf=0.
REQ-033 Gate 0 10,11,10,11,01,00 (reversal) -> exactly one enter pulse; gate 0 10,11,10,00 -> no pulse, occupancy unchanged.
REQ-034 Gate 0 entry and gate 1 exit complete on the same edge at occupancy=5 -> enter[0]=exit[1]=1 same cycle; occupancy stays 5.
REQ-035 Occupancy=CAPACITY (25) plus one entry -> occupancy stays 25, full=1, ovf pulses once; exit at occupancy=0 -> stays 0, ovf pulses.
REQ-036 Gate idle, ab=11 -> err pulse, occupancy unchanged; reset asserted while the gate is in EN2 -> IDLE, occupancy=0, no enter pulse.
